max7219_scheduler: RTL and testbench

//  Sequences every register write to the max7219 serializer (addr/data/start/busy handshake).

---
 rtl/max7219_pkg.sv | 51 +++++
 rtl/max7219_txn.sv | 86 ++++++++
 rtl/max7219_scheduler.sv | 165 ++++++++++++++++
 tb/tb_max7219_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/max7219_pkg.sv
`default_nettype none
// ============================================================================
// max7219_pkg : MAX7219 register map, segment codes and scheduler state codes
// Revision    : 1.0
// ============================================================================
package max7219_pkg;

    localparam logic [7:0] REG_DIGIT0    = 8'h01;
    localparam logic [7:0] REG_DECODE    = 8'h09;
    localparam logic [7:0] REG_INTENSITY = 8'h0A;
    localparam logic [7:0] REG_SCAN      = 8'h0B;
    localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
    localparam logic [7:0] REG_TEST      = 8'h0F;

    // Raw segment bytes: bit7=DP, bit6..0 = A B C D E F G
    localparam logic [7:0] SEG_0     = 8'h7E;
    localparam logic [7:0] SEG_1     = 8'h30;
    localparam logic [7:0] SEG_2     = 8'h6D;
    localparam logic [7:0] SEG_3     = 8'h79;
    localparam logic [7:0] SEG_4     = 8'h33;
    localparam logic [7:0] SEG_5     = 8'h5B;
    localparam logic [7:0] SEG_6     = 8'h5F;
    localparam logic [7:0] SEG_7     = 8'h70;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h7B;
    localparam logic [7:0] SEG_A     = 8'h77;
    localparam logic [7:0] SEG_B     = 8'h1F;
    localparam logic [7:0] SEG_C     = 8'h4E;
    localparam logic [7:0] SEG_D     = 8'h3D;
    localparam logic [7:0] SEG_E     = 8'h4F;
    localparam logic [7:0] SEG_F     = 8'h47;
    localparam logic [7:0] SEG_H     = 8'h37;
    localparam logic [7:0] SEG_L     = 8'h0E;
    localparam logic [7:0] SEG_O     = 8'h7E;
    localparam logic [7:0] SEG_R     = 8'h05;
    localparam logic [7:0] SEG_MINUS = 8'h01;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    localparam logic [1:0] T_IDLE = 2'd0;
    localparam logic [1:0] T_REQ  = 2'd1;
    localparam logic [1:0] T_WAIT = 2'd2;
    localparam logic [1:0] T_GAP  = 2'd3;

    localparam logic [2:0] INIT_TEST   = 3'd0;
    localparam logic [2:0] INIT_SCAN   = 3'd1;
    localparam logic [2:0] INIT_DECODE = 3'd2;
    localparam logic [2:0] INIT_INT    = 3'd3;
    localparam logic [2:0] SERVE       = 3'd4;

endpackage
`default_nettype wire

// File: rtl/max7219_txn.sv
`default_nettype none
// ============================================================================
// max7219_txn : one start/busy handshake with the serializer, with start retry
// Revision    : 1.0
// ============================================================================
import max7219_pkg::*;

module max7219_txn #(
    parameter logic [15:0] START_TIMEOUT = 16'd1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic [7:0] addr,
    input  logic [7:0] data,
    input  logic       max_busy,
    output logic [7:0] max_addr,
    output logic [7:0] max_data,
    output logic       max_start,
    output logic       done,
    output logic       txn_idle
);

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        done    = 1'b0;
        case (state_q)
            T_IDLE: begin
                if (go) begin
                    addr_d  = addr;
                    data_d  = data;
                    cnt_d   = '0;
                    state_d = T_REQ;
                end
            end
            T_REQ: begin
                if (max_busy) begin
                    cnt_d   = '0;
                    state_d = T_WAIT;
                end else if (cnt_q == START_TIMEOUT - 16'd1) begin
                    // serializer missed the request: release start for one cycle
                    cnt_d   = '0;
                    state_d = T_GAP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            T_WAIT: begin
                if (!max_busy) begin
                    done    = 1'b1;
                    state_d = T_IDLE;
                end
            end
            default: state_d = T_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= T_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign max_addr  = addr_q;
    assign max_data  = data_q;
    assign max_start = (state_q == T_REQ);
    assign txn_idle  = (state_q == T_IDLE);

endmodule
`default_nettype wire

// File: rtl/max7219_scheduler.sv
`default_nettype none
// ============================================================================
// max7219_scheduler : init sequence, digit shadow and fixed-priority work arbiter
// Revision          : 1.0
// ============================================================================
import max7219_pkg::*;

module max7219_scheduler #(
    parameter int unsigned NUM_DIGITS    = 8,
    parameter logic [2:0]  SCAN_LIMIT    = 3'd7,
    parameter logic [7:0]  DECODE_MODE   = 8'h00,
    parameter logic [3:0]  INIT_BRIGHT   = 4'h3,
    parameter logic [15:0] START_TIMEOUT = 16'd1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       digit_we,
    input  logic [2:0] digit_sel,
    input  logic [7:0] digit_seg,
    input  logic [3:0] brightness,
    input  logic       blank,
    input  logic       refresh,
    output logic [7:0] max_addr,
    output logic [7:0] max_data,
    output logic       max_start,
    input  logic       max_busy,
    output logic       ready,
    output logic       idle
);

    logic [2:0]            seq_q, seq_d;
    logic [7:0]            shadow_q [NUM_DIGITS];
    logic [7:0]            shadow_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] dirty_q, dirty_d;
    logic                  pend_int_q, pend_int_d;
    logic                  pend_shdn_q, pend_shdn_d;
    logic [3:0]            last_bright_q, last_bright_d;
    logic                  blank_q, blank_d;

    logic                  go, done, txn_idle, has_dirty;
    logic [2:0]            dirty_idx;
    logic [7:0]            sel_addr, sel_data;
    logic                  clr_int, clr_shdn, set_int, set_shdn;
    logic [NUM_DIGITS-1:0] clr_dirty, set_dirty;

    always_comb begin
        seq_d         = seq_q;
        shadow_d      = shadow_q;
        last_bright_d = brightness;
        blank_d       = blank;
        go            = 1'b0;
        sel_addr      = 8'h00;
        sel_data      = 8'h00;
        clr_int       = 1'b0;
        clr_shdn      = 1'b0;
        clr_dirty     = '0;
        has_dirty     = 1'b0;
        dirty_idx     = '0;

        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            if (dirty_q[k]) begin
                has_dirty = 1'b1;
                dirty_idx = 3'(k);
            end
        end

        case (seq_q)
            INIT_TEST: begin
                go       = txn_idle;
                sel_addr = REG_TEST;
            end
            INIT_SCAN: begin
                go       = txn_idle;
                sel_addr = REG_SCAN;
                sel_data = {5'b0, SCAN_LIMIT};
            end
            INIT_DECODE: begin
                go       = txn_idle;
                sel_addr = REG_DECODE;
                sel_data = DECODE_MODE;
            end
            INIT_INT: begin
                // the init intensity write already carries the current brightness
                go       = txn_idle;
                sel_addr = REG_INTENSITY;
                sel_data = {4'b0, brightness};
                clr_int  = txn_idle;
            end
            default: begin
                if (pend_shdn_q) begin
                    sel_addr = REG_SHUTDOWN;
                    sel_data = {7'b0, ~blank};
                    clr_shdn = txn_idle;
                end else if (pend_int_q) begin
                    sel_addr = REG_INTENSITY;
                    sel_data = {4'b0, brightness};
                    clr_int  = txn_idle;
                end else if (has_dirty) begin
                    sel_addr             = {5'b0, dirty_idx} + REG_DIGIT0;
                    sel_data             = shadow_q[dirty_idx];
                    clr_dirty[dirty_idx] = txn_idle;
                end
                go = txn_idle & (pend_shdn_q | pend_int_q | has_dirty);
            end
        endcase

        if (done && (seq_q != SERVE)) begin
            seq_d = seq_q + 3'd1;
        end

        set_int   = refresh | (brightness != last_bright_q);
        set_shdn  = refresh | (blank != blank_q);
        set_dirty = refresh ? '1 : '0;
        if (digit_we && (32'(digit_sel) < NUM_DIGITS)) begin
            set_dirty[digit_sel] = 1'b1;
            shadow_d[digit_sel]  = digit_seg;
        end

        // a set in the latch cycle outranks the clear, re-queueing the item
        pend_int_d  = set_int | (pend_int_q & ~clr_int);
        pend_shdn_d = set_shdn | (pend_shdn_q & ~clr_shdn);
        dirty_d     = set_dirty | (dirty_q & ~clr_dirty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q         <= INIT_TEST;
            for (int k = 0; k < int'(NUM_DIGITS); k++) shadow_q[k] <= 8'h00;
            dirty_q       <= '1;
            pend_int_q    <= 1'b1;
            pend_shdn_q   <= 1'b1;
            last_bright_q <= INIT_BRIGHT;
            blank_q       <= 1'b0;
        end else begin
            seq_q         <= seq_d;
            shadow_q      <= shadow_d;
            dirty_q       <= dirty_d;
            pend_int_q    <= pend_int_d;
            pend_shdn_q   <= pend_shdn_d;
            last_bright_q <= last_bright_d;
            blank_q       <= blank_d;
        end
    end

    max7219_txn #(
        .START_TIMEOUT(START_TIMEOUT)
    ) u_txn (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go),
        .addr     (sel_addr),
        .data     (sel_data),
        .max_busy (max_busy),
        .max_addr (max_addr),
        .max_data (max_data),
        .max_start(max_start),
        .done     (done),
        .txn_idle (txn_idle)
    );

    assign ready = (seq_q == SERVE);
    assign idle  = ready & txn_idle & ~pend_int_q & ~pend_shdn_q & ~|dirty_q;

endmodule
`default_nettype wire

// File: tb/tb_max7219_scheduler.sv
`default_nettype none
// ============================================================================
// tb_max7219_scheduler : directed and random checks against a display-level model
// Revision             : 1.0
// ============================================================================
module tb_max7219_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       digit_we;
    logic [2:0] digit_sel;
    logic [7:0] digit_seg;
    logic [3:0] brightness;
    logic       blank;
    logic       refresh;
    logic [7:0] max_addr;
    logic [7:0] max_data;
    logic       max_start;
    logic       max_busy;
    logic       ready;
    logic       idle;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] obs_a [$];
    logic [7:0] obs_d [$];
    logic       obs_r [$];
    logic [7:0] exp_a [$];
    logic [7:0] exp_d [$];
    logic [7:0] dev_reg [16];
    logic [7:0] ref_shadow [8];

    int         t = 0;
    logic       model_ok = 1'b1;
    logic       prev_start = 1'b0;
    logic [7:0] prev_a, prev_d;

    always #5 clk = ~clk;

    max7219_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .digit_we  (digit_we),
        .digit_sel (digit_sel),
        .digit_seg (digit_seg),
        .brightness(brightness),
        .blank     (blank),
        .refresh   (refresh),
        .max_addr  (max_addr),
        .max_data  (max_data),
        .max_start (max_start),
        .max_busy  (max_busy),
        .ready     (ready),
        .idle      (idle)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Serializer model plus transaction capture, all on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            t          = 0;
            max_busy   = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (prev_start && max_start) begin
                check_eq("addr_stable", {24'b0, max_addr}, {24'b0, prev_a});
                check_eq("data_stable", {24'b0, max_data}, {24'b0, prev_d});
            end
            prev_start = max_start;
            prev_a     = max_addr;
            prev_d     = max_data;
            if (t == 0) begin
                if (max_start && model_ok) t = 1;
            end else begin
                t = t + 1;
                if (t == 3) max_busy = 1'b1;
                if (t == 23) begin
                    max_busy = 1'b0;
                    t        = 0;
                end
            end
            if (max_start && max_busy) begin
                obs_a.push_back(max_addr);
                obs_d.push_back(max_data);
                obs_r.push_back(ready);
                dev_reg[max_addr[3:0]] = max_data;
                check_eq("addr_legal",
                         {31'b0, ((max_addr >= 8'h01) && (max_addr <= 8'h0C)) || (max_addr == 8'h0F)},
                         32'd1);
            end
        end
    end

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        @(negedge clk);
        while (!idle && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check_eq({tag, "_idle_timeout"}, {31'b0, idle}, 32'd1);
    endtask

    task automatic clear_obs();
        obs_a.delete(); obs_d.delete(); obs_r.delete();
        exp_a.delete(); exp_d.delete();
    endtask

    task automatic add_exp(input logic [7:0] a, input logic [7:0] d);
        exp_a.push_back(a);
        exp_d.push_back(d);
    endtask

    task automatic compare_obs(input string tag);
        check_eq({tag, "_count"}, obs_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size(); i++) begin
            if (i < obs_a.size()) begin
                check_eq($sformatf("%s_addr%0d", tag, i), {24'b0, obs_a[i]}, {24'b0, exp_a[i]});
                check_eq($sformatf("%s_data%0d", tag, i), {24'b0, obs_d[i]}, {24'b0, exp_d[i]});
            end
        end
    endtask

    task automatic write_digit(input logic [2:0] sel, input logic [7:0] seg);
        @(negedge clk);
        digit_we  = 1'b1;
        digit_sel = sel;
        digit_seg = seg;
        ref_shadow[sel] = seg;
        @(negedge clk);
        digit_we = 1'b0;
    endtask

    task automatic expect_boot(input logic [3:0] br, input logic bl);
        add_exp(8'h0F, 8'h00);
        add_exp(8'h0B, 8'h07);
        add_exp(8'h09, 8'h00);
        add_exp(8'h0A, {4'b0, br});
        add_exp(8'h0C, {7'b0, ~bl});
        for (int k = 0; k < 8; k++) add_exp(8'(k + 1), 8'h00);
    endtask

    task automatic check_display(input string tag);
        for (int k = 0; k < 8; k++)
            check_eq($sformatf("%s_dig%0d", tag, k), {24'b0, dev_reg[k + 1]}, {24'b0, ref_shadow[k]});
        check_eq({tag, "_int"},  {24'b0, dev_reg[10]}, {28'b0, brightness});
        check_eq({tag, "_shdn"}, {24'b0, dev_reg[12]}, {31'b0, ~blank});
        check_eq({tag, "_scan"}, {24'b0, dev_reg[11]}, 32'h07);
        check_eq({tag, "_dec"},  {24'b0, dev_reg[9]},  32'h00);
    endtask

    initial begin
        int hi, lo, n;
        rst_n      = 1'b0;
        digit_we   = 1'b0;
        digit_sel  = 3'd0;
        digit_seg  = 8'h00;
        brightness = 4'h5;
        blank      = 1'b0;
        refresh    = 1'b0;
        for (int k = 0; k < 16; k++) dev_reg[k] = 8'hEE;
        for (int k = 0; k < 8; k++) ref_shadow[k] = 8'h00;

        // 1: reset state and boot sequence
        repeat (3) @(negedge clk);
        check_eq("rst_start", {31'b0, max_start}, 32'd0);
        check_eq("rst_addr",  {24'b0, max_addr},  32'd0);
        check_eq("rst_data",  {24'b0, max_data},  32'd0);
        check_eq("rst_ready", {31'b0, ready},     32'd0);
        check_eq("rst_idle",  {31'b0, idle},      32'd0);
        clear_obs();
        rst_n = 1'b1;
        expect_boot(4'h5, 1'b0);
        wait_idle("t1", 3000);
        compare_obs("t1");
        for (int i = 0; i < obs_r.size(); i++)
            check_eq($sformatf("t1_ready%0d", i), {31'b0, obs_r[i]}, {31'b0, (i >= 4)});
        check_eq("t1_ready_end", {31'b0, ready}, 32'd1);

        // 2: single digit write from idle
        clear_obs();
        write_digit(3'd2, 8'h7E);
        add_exp(8'h03, 8'h7E);
        wait_idle("t2", 500);
        compare_obs("t2");

        // 3: overwrite of a digit that is in flight
        clear_obs();
        write_digit(3'd5, 8'h11);
        n = 0;
        while (!(max_start && max_addr == 8'h06) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("t3_start_seen", {31'b0, max_start}, 32'd1);
        repeat (5) @(negedge clk);
        write_digit(3'd5, 8'h30);
        check_eq("t3_inflight", {24'b0, max_data}, 32'h11);
        add_exp(8'h06, 8'h11);
        add_exp(8'h06, 8'h30);
        wait_idle("t3", 500);
        compare_obs("t3");

        // 4: shutdown, intensity and digit all pending in the same cycle
        brightness = 4'h3;
        wait_idle("t4a", 500);
        clear_obs();
        @(negedge clk);
        blank      = 1'b1;
        brightness = 4'h9;
        digit_we   = 1'b1;
        digit_sel  = 3'd0;
        digit_seg  = 8'h5A;
        ref_shadow[0] = 8'h5A;
        @(negedge clk);
        digit_we = 1'b0;
        add_exp(8'h0C, 8'h00);
        add_exp(8'h0A, 8'h09);
        add_exp(8'h01, 8'h5A);
        wait_idle("t4", 500);
        compare_obs("t4");

        // random traffic, judged by the final display contents
        for (int r = 0; r < 12; r++) begin
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                digit_we  = ($urandom_range(0, 3) == 0);
                digit_sel = 3'($urandom);
                digit_seg = 8'($urandom);
                if (digit_we) ref_shadow[digit_sel] = digit_seg;
                if ($urandom_range(0, 7) == 0) brightness = 4'($urandom);
                if ($urandom_range(0, 9) == 0) blank = ~blank;
                refresh = ($urandom_range(0, 15) == 0);
            end
            @(negedge clk);
            digit_we = 1'b0;
            refresh  = 1'b0;
            wait_idle($sformatf("rnd%0d", r), 5000);
            check_display($sformatf("rnd%0d", r));
        end

        // 5: serializer never answers, start is retried with the same item
        clear_obs();
        model_ok = 1'b0;
        write_digit(3'd1, 8'h22);
        n = 0;
        while (!max_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        hi = 0;
        while (max_start && hi < 1100) begin
            hi++;
            @(negedge clk);
        end
        lo = 0;
        while (!max_start && lo < 10) begin
            lo++;
            @(negedge clk);
        end
        check_eq("t5_high_run", hi, 32'd1024);
        check_eq("t5_low_run",  lo, 32'd1);
        check_eq("t5_retry_addr", {24'b0, max_addr}, 32'h02);
        check_eq("t5_retry_data", {24'b0, max_data}, 32'h22);
        model_ok = 1'b1;
        add_exp(8'h02, 8'h22);
        wait_idle("t5", 2000);
        compare_obs("t5");
        check_display("t5");

        // 6: reset during a pending request, then a full restart
        model_ok = 1'b0;
        @(negedge clk);
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        n = 0;
        while (!max_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_start_drop", {31'b0, max_start}, 32'd0);
        check_eq("t6_ready_drop", {31'b0, ready},     32'd0);
        brightness = 4'h5;
        blank      = 1'b0;
        model_ok   = 1'b1;
        for (int k = 0; k < 8; k++) ref_shadow[k] = 8'h00;
        repeat (2) @(negedge clk);
        clear_obs();
        rst_n = 1'b1;
        expect_boot(4'h5, 1'b0);
        wait_idle("t6", 3000);
        compare_obs("t6");
        check_display("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
